// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU command sequencer.
// The FSM state type, the opcode unit-select codes and the datapath widths
// live here so the controller and its response FIFO agree on them.
package alu_seq_pkg;

  localparam int OP_W   = 6;          // opcode: [5:3] unit, [2:0] mode
  localparam int OPND_W = 8;          // ALU operand width
  localparam int RES_W  = 16;         // ALU result width
  localparam int RSP_W  = RES_W + 1;  // FIFO word: {err, data}

  // Unit-select codes carried in opcode bits [5:3].
  localparam logic [2:0] UNIT_ADD = 3'b000;
  localparam logic [2:0] UNIT_MUL = 3'b001;
  localparam logic [2:0] UNIT_SHF = 3'b010;
  localparam logic [2:0] UNIT_LOG = 3'b011;
  localparam logic [2:0] UNIT_CMP = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Unit codes above CMP (101, 110, 111) have no ALU unit behind them.
  function automatic logic unit_reserved(input logic [OP_W-1:0] op);
    return op[5:3] > UNIT_CMP;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous-reset response FIFO holding {err, data} words.
// DEPTH must be a power of two so the pointers wrap naturally.
// The head word reads as zero while the FIFO is empty.
module alu_rsp_fifo
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_en;
  logic             pop_en;

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write; entries are only ever read after being written.
  // NOTE: the storage array is deliberately not reset -- empty/count gate every
  // read, and leaving it out keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; a push and pop together leave count as is.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences single commands through an external combinational
// ALU (IDLE -> ISSUE -> CAPTURE) and queues results in a response FIFO.
// Optional feature macro ALU_SEQ_OPCHK_EN: reserved unit codes (101/110/111)
// are answered directly with an error response instead of being issued.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  output logic [OPND_W-1:0] alu_A,
  output logic [OPND_W-1:0] alu_B,
  output logic [OP_W-1:0]   alu_OP,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic              rsp_err,
  output logic [RES_W-1:0]  op_count
);

`ifdef ALU_SEQ_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  state_t           state;
  logic             err_pend;   // command in flight is a rejected opcode
  logic             bad_op;
  logic             cmd_fire;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [RSP_W-1:0] push_word;
  logic [RSP_W-1:0] head_word;

  // Accept only from IDLE with a guaranteed free slot, never while in reset.
  assign cmd_ready = !rst && (state == IDLE) && !fifo_full;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign bad_op    = OPCHK && unit_reserved(cmd_op);
  assign push      = (state == CAPTURE);
  assign pop       = rsp_valid && rsp_ready;
  assign push_word = err_pend ? {1'b1, {RES_W{1'b0}}} : {1'b0, alu_result};

  assign rsp_valid           = !fifo_empty;
  assign {rsp_err, rsp_data} = head_word;

  // Command FSM; ALU operand registers load only on an issued handshake and
  // otherwise hold, so the ALU inputs stay quiet between commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      err_pend <= 1'b0;
      alu_A    <= '0;
      alu_B    <= '0;
      alu_OP   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (bad_op) begin
              // Rejected opcode skips the ALU settle cycle entirely.
              err_pend <= 1'b1;
              state    <= CAPTURE;
            end else begin
              err_pend <= 1'b0;
              alu_A    <= cmd_a;
              alu_B    <= cmd_b;
              alu_OP   <= cmd_op;
              state    <= ISSUE;
            end
          end
        end
        ISSUE:   state <= CAPTURE;   // one cycle for the ALU to settle
        CAPTURE: state <= IDLE;      // result pushed on this edge
        default: state <= IDLE;
      endcase
    end
  end

  // Completed-operation counter, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (push && (op_count != '1)) begin
      op_count <= op_count + RES_W'(1);
    end
  end

  alu_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RSP_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (head_word),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench for alu_seq_ctrl. The bench plays the
// role of alu_8bit with a behavioural ALU and keeps a queue of expected
// responses filled at every command handshake and drained at every response
// handshake. Inputs change 1 ns after the rising edge; the scoreboard samples
// on the falling edge.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [5:0]  cmd_op, alu_OP;
  logic [7:0]  cmd_a, cmd_b, alu_A, alu_B;
  logic [15:0] alu_result, rsp_data, op_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [16:0] exp_q[$];
  logic [16:0] sb_exp;
  int          accepted   = 0;   // handshakes since last reset
  int          popped     = 0;   // response handshakes seen
  int          cnt_offset = 0;   // op_count preload applied by force
  bit          rand_ready = 1'b0;
  int          n, p0, lat;

  always #5 clk = ~clk;

  // Behavioural ALU standing in for alu_8bit.
  function automatic logic [15:0] alu_model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    r = 16'h0000;
    case (op[5:3])
      3'b000: r = op[0] ? ({8'h00, a} - {8'h00, b}) : ({8'h00, a} + {8'h00, b});
      3'b001: r = op[0] ? ({{8{a[7]}}, a} * {{8{b[7]}}, b}) : ({8'h00, a} * {8'h00, b});
      3'b010: r = {8'h00, a} << b[2:0];
      3'b011: begin
        case (op[1:0])
          2'd0:    r = {8'h00, a & b};
          2'd1:    r = {8'h00, a | b};
          2'd2:    r = {8'h00, a ^ b};
          default: r = {8'h00, ~a};
        endcase
      end
      3'b100: r = op[0] ? {15'h0, a == b} : {15'h0, a < b};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  assign alu_result = alu_model(alu_OP, alu_A, alu_B);

  // Expected FIFO word {err, data} for an accepted command.
  function automatic logic [16:0] expected_rsp(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
`ifdef ALU_SEQ_OPCHK_EN
    if (op[5:3] > 3'd4) return {1'b1, 16'h0000};
`endif
    return {1'b0, alu_model(op, a, b)};
  endfunction

  function automatic logic [15:0] exp_count();
    longint t;
    t = longint'(accepted) + longint'(cnt_offset);
    return (t > 64'hFFFF) ? 16'hFFFF : 16'(t);
  endfunction

  alu_seq_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_OP     (alu_OP),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .op_count   (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: handshakes are decided by values stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      accepted = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        popped++;
        check("rsp_expected_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          sb_exp = exp_q.pop_front();
          check("rsp_head_word", {15'h0, rsp_err, rsp_data}, {15'h0, sb_exp});
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(expected_rsp(cmd_op, cmd_a, cmd_b));
        accepted++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    end
    check({tag, "_accept_timeout"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    wait_accept(tag);
  endtask

  // Pop everything, including any command still in flight; returns pop count.
  task automatic drain(input string tag, output int cnt);
    int start, quiet;
    start = popped;
    quiet = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && quiet < 4; i++) begin
      tick();
      if (rsp_valid) quiet = 0; else quiet++;
    end
    rsp_ready = 1'b0;
    check({tag, "_model_empty"}, 32'(exp_q.size()), 0);
    check({tag, "_op_count"}, op_count, exp_count());
    cnt = popped - start;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_A", alu_A, 0);
    check("rst_alu_B", alu_B, 0);
    check("rst_alu_OP", alu_OP, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0; cnt_offset = 0;
    tick();
    check("ready_after_rst", cmd_ready, 1);

    // MUL unsigned: latency and result
    send("mul_u", 6'b001000, 8'd15, 8'd17);
    check("mul_u_alu_A", alu_A, 15);
    check("mul_u_alu_B", alu_B, 17);
    check("mul_u_alu_OP", alu_OP, 6'b001000);
    check("mul_u_ready_busy", cmd_ready, 0);
    check("mul_u_lat_issue", rsp_valid, 0);
    tick();
    check("mul_u_lat_capture", rsp_valid, 0);
    tick();
    check("mul_u_rsp_valid", rsp_valid, 1);
    check("mul_u_rsp_data", rsp_data, 16'h00FF);
    check("mul_u_rsp_err", rsp_err, 0);
    check("mul_u_op_count", op_count, 1);
    check("mul_u_ready_again", cmd_ready, 1);
    drain("mul_u", n);

    // MUL signed
    send("mul_s", 6'b001001, 8'hFF, 8'hFF);
    tick(); tick();
    check("mul_s_rsp_data", rsp_data, 16'h0001);
    drain("mul_s", n);

    // ALU inputs hold while idle even as the command bus changes
    for (int i = 0; i < 5; i++) begin
      cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 6'($urandom);
      tick();
    end
    check("idle_hold_A", alu_A, 8'hFF);
    check("idle_hold_B", alu_B, 8'hFF);
    check("idle_hold_OP", alu_OP, 6'b001001);

    // Backpressure: four fill the FIFO, the fifth waits
    for (int i = 0; i < 4; i++) send("bp_fill", 6'b011000, 8'hF0, 8'h3C);
    cmd_op = 6'b011000; cmd_a = 8'hF0; cmd_b = 8'h3C; cmd_valid = 1'b1;
    repeat (6) tick();
    check("bp_ready_low", cmd_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_head", rsp_data, 16'h0030);
    check("bp_op_count", op_count, exp_count());
    p0 = popped;
    rsp_ready = 1'b1;
    wait_accept("bp_fifth");
    drain("bp", n);
    check("bp_total_drained", 32'(popped - p0), 5);

    // Reserved unit code 111
    send("opchk", 6'b111000, 8'h5A, 8'hA5);
    lat = 0;
    for (int i = 0; i < 10 && !rsp_valid; i++) begin
      tick();
      lat++;
    end
    check("opchk_rsp_data", rsp_data, 16'h0000);
`ifdef ALU_SEQ_OPCHK_EN
    check("opchk_latency", lat, 1);
    check("opchk_rsp_err", rsp_err, 1);
    check("opchk_alu_OP_held", alu_OP, 6'b011000);
`else
    check("opchk_latency", lat, 2);
    check("opchk_rsp_err", rsp_err, 0);
    check("opchk_alu_OP", alu_OP, 6'b111000);
`endif
    drain("opchk", n);

    // Simultaneous push and pop at occupancy 2
    send("pp_a", 6'b000000, 8'd1, 8'd2);
    send("pp_b", 6'b000000, 8'd3, 8'd4);
    tick(); tick();
    send("pp_c", 6'b000000, 8'd5, 8'd6);
    tick();
    check("pp_head_a", rsp_data, 16'd3);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("pp_head_b", rsp_data, 16'd7);
    drain("pp", n);
    check("pp_occupancy_kept", n, 2);

    // Randomized commands with random response backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send("rand", 6'($urandom), 8'($urandom), 8'($urandom));
    end
    rand_ready = 1'b0;
    drain("rand", n);

    // op_count saturation
    force dut.op_count = 16'hFFFE;
    tick();
    release dut.op_count;
    cnt_offset = 32'hFFFE - accepted;
    check("sat_preload", op_count, 16'hFFFE);
    send("sat_1", 6'b000000, 8'd9, 8'd9);
    drain("sat_1", n);
    check("sat_first", op_count, 16'hFFFF);
    send("sat_2", 6'b000000, 8'd9, 8'd9);
    drain("sat_2", n);
    check("sat_second", op_count, 16'hFFFF);

    // Reset while in ISSUE drops the command
    send("rst_mid", 6'b000000, 8'h11, 8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0; cnt_offset = 0;
    repeat (5) tick();
    check("rst_mid_no_rsp", rsp_valid, 0);
    check("rst_mid_op_count", op_count, 0);
    send("post_rst", 6'b000000, 8'h11, 8'h22);
    tick(); tick();
    check("post_rst_valid", rsp_valid, 1);
    check("post_rst_data", rsp_data, 16'h0033);
    check("post_rst_op_count", op_count, 1);
    drain("post_rst", n);
    check("post_rst_pops", n, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
